axi_lite_cfg_sequencer: RTL and testbench
=========================================

Name: axi_lite_cfg_sequencer

Overview:
AXI4-Lite master that configures a register-mapped peripheral slave with NUM_REGS 32-bit words. On each start it writes each word to consecutive word addresses, reads it back, and compares. It reports done, error class and failing index. It sits between the control logic and the slave, and is the hardware equivalent of a write/read-back bench sequence.

Parameters:
C_ADDR_WIDTH, 32, AXI address width
C_DATA_WIDTH, 32, AXI data width (fixed 32; WSTRB = 4'hF)
C_NUM_REGS, 4, number of registers sequenced (1..16)
C_BASE_ADDR, 32'h0, address of register 0; register i at C_BASE_ADDR + 4*i
C_TIMEOUT, 255, max cycles waiting on any single handshake

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESET  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to run a sequence
cfg_data  in  32*C_NUM_REGS  flattened write values, word i at [32*i+31:32*i]; sampled into a shadow copy on accepted start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at sequence end
err_code  out  2  00 none, 01 bad BRESP/RRESP, 10 read-back mismatch, 11 timeout; held until next start
err_index  out  4  register index of first error; held
M_AXI_AWADDR/AWPROT/AWVALID/AWREADY  out/out/out/in  C_ADDR_WIDTH/3/1/1  write address channel, AWPROT=0
M_AXI_WDATA/WSTRB/WVALID/WREADY  out/out/out/in  32/4/1/1  write data channel
M_AXI_BRESP/BVALID/BREADY  in/in/out  2/1/1  write response channel
M_AXI_ARADDR/ARPROT/ARVALID/ARREADY  out/out/out/in  C_ADDR_WIDTH/3/1/1  read address channel, ARPROT=0
M_AXI_RDATA/RRESP/RVALID/RREADY  in/in/in/out  32/2/1/1  read data channel

Behaviour:
- Reset: all VALID/READY outputs 0; addresses and data 0; busy=0, done=0, err_code=00, err_index=0; FSM=IDLE; index=0.
- FSM: IDLE -> WR (AWVALID and WVALID both asserted in the same cycle) -> WR_RESP -> RD_ADDR -> RD_DATA -> NEXT -> (WR for the next index | FINISH) -> IDLE.
- IDLE: start=1 latches cfg_data, clears err_code/err_index, sets busy, index=0. start while busy is ignored.
- WR: AWVALID drops on the cycle after AW handshake and WVALID drops on the cycle after W handshake, each independently. Move to WR_RESP once both have completed, including completion in the same cycle.
- WR_RESP: BREADY=1. On BVALID, BRESP!=00 sets err=01 and goes to FINISH; otherwise goes to RD_ADDR.
- RD_ADDR: ARVALID=1 until ARREADY. RD_DATA: RREADY=1. On RVALID, RRESP!=00 sets err=01; RDATA!=shadow[index] sets err=10. Either error goes to FINISH.
- NEXT: if index==C_NUM_REGS-1 go to FINISH, else index+1 and go to WR.
- Address: C_BASE_ADDR + {index,2'b00}, truncated to C_ADDR_WIDTH; wrap is permitted.
- VALID, once raised, holds with stable ADDR/DATA until handshake (AXI rule).
- Timeout: a counter resets on state entry and increments while waiting in WR, WR_RESP, RD_ADDR or RD_DATA. Reaching C_TIMEOUT sets err=11, drops all VALIDs, and goes to FINISH.
- FINISH: done=1 for one cycle, busy=0, then IDLE. err_index = index at the first error.
- Min latency per register with zero-wait slave: WR 1, WR_RESP 1, RD_ADDR 1, RD_DATA 1, NEXT 1 = 5 cycles. done follows the last NEXT by one cycle.
- Reset mid-operation: all outputs return to reset values immediately. The slave must share ARESET; no transaction resume.

Decomposition:
- Package: FSM state encoding, err_code constants (ERR_NONE/ERR_RESP/ERR_MISMATCH/ERR_TIMEOUT), RESP_OKAY=2'b00.
- Sub-module: axi_lite_cfg_timeout, a loadable down-counter with clear and expired flag. Everything else lives in the single FSM module.

Test Plan:
- Zero-wait slave, cfg = 0101FFFF, abcd0001, dead0011, beef0011 -> four writes to 0x0, 0x4, 0x8, 0xC, matching reads; done after 20 cycles; err_code=00.
- AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops first, AWVALID holds with stable address; sequence completes with err=00.
- Slave returns RDATA for reg2 = dead0010 -> err_code=10, err_index=2, no access to 0xC, single done pulse.
- BRESP=2'b10 on reg1 write -> err_code=01, err_index=1, no read issued for reg1.
- ARREADY held low, C_TIMEOUT=8 -> ARVALID drops after 8 cycles, err_code=11, done pulses; a later start with a good slave passes with err cleared.
- ARESET pulsed while in WR_RESP -> all VALID/READY low combinationally, busy=0; a new start replays from index 0.

Source files
------------

// File: rtl/axi_lite_cfg_sequencer_pkg.sv
//------------------------------------------------------------------------------
// axi_lite_cfg_sequencer_pkg: FSM states and status codes. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package axi_lite_cfg_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_NEXT    = 3'd5,
    ST_FINISH  = 3'd6
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_RESP     = 2'b01;
  localparam logic [1:0] ERR_MISMATCH = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  localparam logic [1:0] RESP_OKAY    = 2'b00;

endpackage

`default_nettype wire

// File: rtl/axi_lite_cfg_sequencer_timeout.sv
//------------------------------------------------------------------------------
// axi_lite_cfg_timeout: loadable down-counter with clear and expired flag. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module axi_lite_cfg_timeout #(
  parameter int C_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam int              c_tw   = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT) : 1;
  localparam logic [c_tw-1:0] c_load = c_tw'(C_TIMEOUT - 1);

  logic [c_tw-1:0] r_count;

  // Loaded with C_TIMEOUT-1 so that zero is reached on the C_TIMEOUT-th waiting cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= c_load;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - c_tw'(1);
    end
  end

  assign o_expired = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/axi_lite_cfg_sequencer.sv
//------------------------------------------------------------------------------
// axi_lite_cfg_sequencer: AXI4-Lite write/read-back configuration master. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module axi_lite_cfg_sequencer
  import axi_lite_cfg_sequencer_pkg::*;
#(
  parameter int                      C_ADDR_WIDTH = 32,
  parameter int                      C_DATA_WIDTH = 32,
  parameter int                      C_NUM_REGS   = 4,
  parameter logic [C_ADDR_WIDTH-1:0] C_BASE_ADDR  = '0,
  parameter int                      C_TIMEOUT    = 255
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      start,
  input  logic [32*C_NUM_REGS-1:0]  cfg_data,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                err_code,
  output logic [3:0]                err_index,
  output logic [C_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                M_AXI_AWPROT,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [C_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [3:0]                M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  output logic [C_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                M_AXI_ARPROT,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  input  logic [C_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY
);

  state_t                    r_state;
  logic [3:0]                r_index;
  logic [32*C_NUM_REGS-1:0]  r_shadow;
  logic                      r_aw_done;
  logic                      r_w_done;
  logic [C_ADDR_WIDTH-1:0]   r_awaddr;
  logic [C_ADDR_WIDTH-1:0]   r_araddr;
  logic [C_DATA_WIDTH-1:0]   r_wdata;
  logic                      r_awvalid;
  logic                      r_wvalid;
  logic                      r_bready;
  logic                      r_arvalid;
  logic                      r_rready;
  logic                      r_busy;
  logic                      r_done;
  logic [1:0]                r_err_code;
  logic [3:0]                r_err_index;

  logic                      w_aw_hs;
  logic                      w_w_hs;
  logic                      w_wr_ok;
  logic [3:0]                w_idx_nxt;
  logic [31:0]               w_rd_exp;
  logic [31:0]               w_wr_nxt;
  logic                      w_in_wait;
  logic                      w_advance;
  logic                      w_stall;
  logic                      w_tmo_load;
  logic                      w_tmo_clr;
  logic                      w_expired;
  logic                      w_timeout;

  function automatic logic [C_ADDR_WIDTH-1:0] f_addr(input logic [3:0] idx);
    return C_BASE_ADDR + C_ADDR_WIDTH'({idx, 2'b00});
  endfunction

  assign w_aw_hs   = r_awvalid & M_AXI_AWREADY;
  assign w_w_hs    = r_wvalid & M_AXI_WREADY;
  assign w_wr_ok   = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);
  assign w_idx_nxt = r_index + 4'd1;
  assign w_rd_exp  = r_shadow[32*r_index +: 32];
  assign w_wr_nxt  = r_shadow[32*w_idx_nxt +: 32];

  always_comb begin
    w_in_wait = 1'b0;
    w_advance = 1'b0;
    case (r_state)
      ST_WR:      begin w_in_wait = 1'b1; w_advance = w_wr_ok;       end
      ST_WR_RESP: begin w_in_wait = 1'b1; w_advance = M_AXI_BVALID;  end
      ST_RD_ADDR: begin w_in_wait = 1'b1; w_advance = M_AXI_ARREADY; end
      ST_RD_DATA: begin w_in_wait = 1'b1; w_advance = M_AXI_RVALID;  end
      default:    ;
    endcase
  end

  // Any cycle that is not a stall reloads the counter, so each state entry starts fresh.
  assign w_stall    = w_in_wait & ~w_advance;
  assign w_tmo_load = ~w_stall;
  assign w_tmo_clr  = (r_state == ST_FINISH);
  assign w_timeout  = w_stall & w_expired;

  axi_lite_cfg_timeout #(
    .C_TIMEOUT (C_TIMEOUT)
  ) u_timeout (
    .clk       (ACLK),
    .rst       (ARESET),
    .i_clr     (w_tmo_clr),
    .i_load    (w_tmo_load),
    .i_en      (w_stall),
    .o_expired (w_expired)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state     <= ST_IDLE;
      r_index     <= '0;
      r_shadow    <= '0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_awaddr    <= '0;
      r_araddr    <= '0;
      r_wdata     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_err_index <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_timeout) begin
        r_awvalid   <= 1'b0;
        r_wvalid    <= 1'b0;
        r_bready    <= 1'b0;
        r_arvalid   <= 1'b0;
        r_rready    <= 1'b0;
        r_err_code  <= ERR_TIMEOUT;
        r_err_index <= r_index;
        r_busy      <= 1'b0;
        r_done      <= 1'b1;
        r_state     <= ST_FINISH;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_shadow    <= cfg_data;
              r_err_code  <= ERR_NONE;
              r_err_index <= '0;
              r_busy      <= 1'b1;
              r_index     <= '0;
              r_awaddr    <= f_addr(4'd0);
              r_wdata     <= cfg_data[31:0];
              r_awvalid   <= 1'b1;
              r_wvalid    <= 1'b1;
              r_aw_done   <= 1'b0;
              r_w_done    <= 1'b0;
              r_state     <= ST_WR;
            end
          end
          ST_WR: begin
            if (w_aw_hs) begin
              r_awvalid <= 1'b0;
              r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
              r_wvalid <= 1'b0;
              r_w_done <= 1'b1;
            end
            if (w_wr_ok) begin
              r_bready <= 1'b1;
              r_state  <= ST_WR_RESP;
            end
          end
          ST_WR_RESP: begin
            if (M_AXI_BVALID) begin
              r_bready <= 1'b0;
              if (M_AXI_BRESP != RESP_OKAY) begin
                r_err_code  <= ERR_RESP;
                r_err_index <= r_index;
                r_busy      <= 1'b0;
                r_done      <= 1'b1;
                r_state     <= ST_FINISH;
              end else begin
                r_araddr  <= r_awaddr;
                r_arvalid <= 1'b1;
                r_state   <= ST_RD_ADDR;
              end
            end
          end
          ST_RD_ADDR: begin
            if (M_AXI_ARREADY) begin
              r_arvalid <= 1'b0;
              r_rready  <= 1'b1;
              r_state   <= ST_RD_DATA;
            end
          end
          ST_RD_DATA: begin
            if (M_AXI_RVALID) begin
              r_rready <= 1'b0;
              if ((M_AXI_RRESP != RESP_OKAY) || (M_AXI_RDATA != w_rd_exp)) begin
                r_err_code  <= (M_AXI_RRESP != RESP_OKAY) ? ERR_RESP : ERR_MISMATCH;
                r_err_index <= r_index;
                r_busy      <= 1'b0;
                r_done      <= 1'b1;
                r_state     <= ST_FINISH;
              end else begin
                r_state <= ST_NEXT;
              end
            end
          end
          ST_NEXT: begin
            if (r_index == 4'(C_NUM_REGS - 1)) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_FINISH;
            end else begin
              r_index   <= w_idx_nxt;
              r_awaddr  <= f_addr(w_idx_nxt);
              r_wdata   <= w_wr_nxt;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
              r_state   <= ST_WR;
            end
          end
          ST_FINISH: r_state <= ST_IDLE;
          default:   r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign err_code      = r_err_code;
  assign err_index     = r_err_index;
  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_araddr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_cfg_sequencer.sv
//------------------------------------------------------------------------------
// tb_axi_lite_cfg_sequencer: directed bench with a configurable AXI4-Lite slave. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_axi_lite_cfg_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] cfg_data = '0;
  logic         busy, done;
  logic [1:0]   err_code;
  logic [3:0]   err_index;
  logic [31:0]  awaddr, wdata, araddr, rdata;
  logic [2:0]   awprot, arprot;
  logic [3:0]   wstrb;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [1:0]   bresp, rresp;

  always #5 clk = ~clk;

  axi_lite_cfg_sequencer #(
    .C_ADDR_WIDTH (32),
    .C_DATA_WIDTH (32),
    .C_NUM_REGS   (4),
    .C_BASE_ADDR  (32'h0),
    .C_TIMEOUT    (8)
  ) dut (
    .ACLK          (clk),
    .ARESET        (rst),
    .start         (start),
    .cfg_data      (cfg_data),
    .busy          (busy),
    .done          (done),
    .err_code      (err_code),
    .err_index     (err_index),
    .M_AXI_AWADDR  (awaddr),
    .M_AXI_AWPROT  (awprot),
    .M_AXI_AWVALID (awvalid),
    .M_AXI_AWREADY (awready),
    .M_AXI_WDATA   (wdata),
    .M_AXI_WSTRB   (wstrb),
    .M_AXI_WVALID  (wvalid),
    .M_AXI_WREADY  (wready),
    .M_AXI_BRESP   (bresp),
    .M_AXI_BVALID  (bvalid),
    .M_AXI_BREADY  (bready),
    .M_AXI_ARADDR  (araddr),
    .M_AXI_ARPROT  (arprot),
    .M_AXI_ARVALID (arvalid),
    .M_AXI_ARREADY (arready),
    .M_AXI_RDATA   (rdata),
    .M_AXI_RRESP   (rresp),
    .M_AXI_RVALID  (rvalid),
    .M_AXI_RREADY  (rready)
  );

  // Slave behaviour knobs
  int          aw_delay = 0;
  bit          ar_block = 1'b0;
  bit          bresp_bad = 1'b0;
  logic [3:0]  bresp_idx = '0;
  bit          rd_bad = 1'b0;
  logic [3:0]  rd_idx = '0;
  logic [31:0] rd_val = '0;
  bit          clr_log = 1'b0;

  int          aw_cnt;
  logic        got_aw, got_w;
  logic [31:0] h_addr, h_data;
  logic        aw_hs, w_hs, ar_hs, wr_cmpl;
  logic [31:0] wa, wd;

  logic [31:0] mem [16];
  int          wr_cnt [16];
  int          rd_cnt [16];
  int          ar_hi;
  int          aw_unstable;
  bit          w_first;
  bit          first_seen;
  logic [31:0] first_waddr;
  logic        prev_awpend;
  logic [31:0] prev_awaddr;

  assign awready = awvalid && (aw_cnt >= aw_delay);
  assign wready  = wvalid;
  assign arready = arvalid && !ar_block;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign ar_hs   = arvalid && arready;
  assign wa      = aw_hs ? awaddr : h_addr;
  assign wd      = w_hs ? wdata : h_data;
  assign wr_cmpl = (got_aw || aw_hs) && (got_w || w_hs);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_cnt <= 0;
      got_aw <= 1'b0;
      got_w  <= 1'b0;
      h_addr <= '0;
      h_data <= '0;
      bvalid <= 1'b0;
      bresp  <= 2'b00;
      rvalid <= 1'b0;
      rresp  <= 2'b00;
      rdata  <= '0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      if (aw_hs) begin got_aw <= 1'b1; h_addr <= awaddr; end
      if (w_hs)  begin got_w  <= 1'b1; h_data <= wdata;  end
      if (bvalid && bready) bvalid <= 1'b0;
      if (wr_cmpl) begin
        got_aw <= 1'b0;
        got_w  <= 1'b0;
        bvalid <= 1'b1;
        bresp  <= (bresp_bad && wa[5:2] == bresp_idx) ? 2'b10 : 2'b00;
      end
      if (rvalid && rready) rvalid <= 1'b0;
      if (ar_hs) begin
        rvalid <= 1'b1;
        rresp  <= 2'b00;
        rdata  <= (rd_bad && araddr[5:2] == rd_idx) ? rd_val : mem[araddr[5:2]];
      end
    end
  end

  always @(posedge clk) begin
    if (clr_log || rst) begin
      for (int i = 0; i < 16; i++) begin
        if (clr_log) begin
          mem[i]    <= '0;
          wr_cnt[i] <= 0;
          rd_cnt[i] <= 0;
        end
      end
      if (clr_log) begin
        ar_hi       <= 0;
        aw_unstable <= 0;
        w_first     <= 1'b0;
        first_seen  <= 1'b0;
        first_waddr <= '0;
      end
      prev_awpend <= 1'b0;
      prev_awaddr <= '0;
    end else begin
      if (wr_cmpl) begin
        wr_cnt[wa[5:2]] <= wr_cnt[wa[5:2]] + 1;
        if (!(bresp_bad && wa[5:2] == bresp_idx)) mem[wa[5:2]] <= wd;
        if (!first_seen) begin
          first_seen  <= 1'b1;
          first_waddr <= wa;
        end
      end
      if (ar_hs) rd_cnt[araddr[5:2]] <= rd_cnt[araddr[5:2]] + 1;
      if (arvalid) ar_hi <= ar_hi + 1;
      if (awvalid && !wvalid) w_first <= 1'b1;
      if (prev_awpend && (!awvalid || awaddr != prev_awaddr)) aw_unstable <= aw_unstable + 1;
      prev_awpend <= awvalid && !awready;
      prev_awaddr <= awaddr;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    @(negedge clk);
    clr_log = 1'b1;
    @(negedge clk);
    clr_log = 1'b0;
  endtask

  // Pulses start, returns posedges from the start-sampling edge until done.
  task automatic run(input string tag, output int cyc);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ":busy"}, 64'(busy), 64'd1);
    cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, ":done"}, 64'(done), 64'd1);
    chk({tag, ":busy_at_done"}, 64'(busy), 64'd0);
    @(negedge clk);
    chk({tag, ":done_pulse"}, 64'(done), 64'd0);
  endtask

  logic [31:0] t1_words [4] = '{32'h0101FFFF, 32'habcd0001, 32'hdead0011, 32'hbeef0011};

  initial begin
    int cyc;
    int k;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst:handshake_out", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
    chk("rst:busy_done", 64'({busy, done}), 64'd0);
    chk("rst:err", 64'({err_code, err_index}), 64'd0);
    chk("rst:addr_data", 64'({awaddr, wdata}), 64'd0);
    chk("rst:araddr", 64'(araddr), 64'd0);

    // Zero-wait slave, four registers
    cfg_data = {32'hbeef0011, 32'hdead0011, 32'habcd0001, 32'h0101FFFF};
    clr();
    run("t1", cyc);
    chk("t1:cycles", 64'(cyc), 64'd20);
    chk("t1:err", 64'({err_code, err_index}), 64'd0);
    chk("t1:first_waddr", 64'(first_waddr), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1:mem%0d", i), 64'(mem[i]), 64'(t1_words[i]));
      chk($sformatf("t1:wr_cnt%0d", i), 64'(wr_cnt[i]), 64'd1);
      chk($sformatf("t1:rd_cnt%0d", i), 64'(rd_cnt[i]), 64'd1);
    end

    // AWREADY delayed by three cycles
    aw_delay = 3;
    clr();
    run("t2", cyc);
    chk("t2:cycles", 64'(cyc), 64'd32);
    chk("t2:err", 64'(err_code), 64'd0);
    chk("t2:w_drops_first", 64'(w_first), 64'd1);
    chk("t2:aw_stable", 64'(aw_unstable), 64'd0);
    aw_delay = 0;

    // Read-back mismatch on register 2
    rd_bad = 1'b1;
    rd_idx = 4'd2;
    rd_val = 32'hdead0010;
    clr();
    run("t3", cyc);
    chk("t3:cycles", 64'(cyc), 64'd14);
    chk("t3:err_code", 64'(err_code), 64'd2);
    chk("t3:err_index", 64'(err_index), 64'd2);
    repeat (3) @(negedge clk);
    chk("t3:no_wr_reg3", 64'(wr_cnt[3]), 64'd0);
    chk("t3:no_rd_reg3", 64'(rd_cnt[3]), 64'd0);
    chk("t3:done_idle", 64'({done, busy}), 64'd0);
    rd_bad = 1'b0;

    // SLVERR on the register 1 write
    bresp_bad = 1'b1;
    bresp_idx = 4'd1;
    clr();
    run("t4", cyc);
    chk("t4:cycles", 64'(cyc), 64'd7);
    chk("t4:err_code", 64'(err_code), 64'd1);
    chk("t4:err_index", 64'(err_index), 64'd1);
    chk("t4:wr_reg1", 64'(wr_cnt[1]), 64'd1);
    chk("t4:no_rd_reg1", 64'(rd_cnt[1]), 64'd0);
    bresp_bad = 1'b0;

    // ARREADY stuck low, timeout of 8
    ar_block = 1'b1;
    clr();
    run("t5", cyc);
    chk("t5:cycles", 64'(cyc), 64'd10);
    chk("t5:err_code", 64'(err_code), 64'd3);
    chk("t5:err_index", 64'(err_index), 64'd0);
    chk("t5:arvalid_cycles", 64'(ar_hi), 64'd8);
    chk("t5:arvalid_low", 64'(arvalid), 64'd0);
    ar_block = 1'b0;
    clr();
    run("t5b", cyc);
    chk("t5b:cycles", 64'(cyc), 64'd20);
    chk("t5b:err", 64'({err_code, err_index}), 64'd0);

    // Reset while waiting for the write response
    cfg_data = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    clr();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!bready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("t6:in_wr_resp", 64'(bready), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6:rst_handshake", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
    chk("t6:rst_busy", 64'({busy, done}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    clr();
    run("t6", cyc);
    chk("t6:cycles", 64'(cyc), 64'd20);
    chk("t6:err", 64'({err_code, err_index}), 64'd0);
    chk("t6:first_waddr", 64'(first_waddr), 64'd0);
    chk("t6:wr_reg0", 64'(wr_cnt[0]), 64'd1);
    chk("t6:mem3", 64'(mem[3]), 64'h11111111);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
